// File: rtl/crc_pkg.sv
// Shared CRC-4 definitions for the generator/checker pair.
// Holds the polynomial, widths and the checker FSM state encoding.
package crc_pkg;

  localparam logic [4:0]  POLY_CRC4 = 5'b10011;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned CRC_W     = 4;
  localparam int unsigned CW        = DATA_W + CRC_W;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StDivide = 2'd1;
  localparam state_t StDone   = 2'd2;

endpackage

// File: rtl/crc_checker_if.sv
// Codeword input stream and checked-result output stream of the CRC checker.
// The master drives codewords and accepts results; the slave is the checker.
interface crc_checker_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CRC_W  = 4
);

  logic                      in_valid;
  logic [DATA_W+CRC_W-1:0]   in_codeword;
  logic                      in_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic [CRC_W-1:0]          out_syndrome;
  logic                      out_crc_err;

  modport master (
    output in_valid, in_codeword, out_ready,
    input  in_ready, out_valid, out_data, out_syndrome, out_crc_err
  );

  modport slave (
    input  in_valid, in_codeword, out_ready,
    output in_ready, out_valid, out_data, out_syndrome, out_crc_err
  );

endinterface

// File: rtl/crc_serial_div.sv
// Bit-serial polynomial divider: shifts one bit per enabled cycle into the remainder.
// rem_next exposes the post-step value so a caller can capture the final remainder early.
module crc_serial_div #(
  parameter int unsigned        CRC_W = 4,
  parameter logic [CRC_W:0]     POLY  = 5'b10011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             bit_in,
  output logic [CRC_W-1:0] rem,
  output logic [CRC_W-1:0] rem_next
);

  // The leading x^CRC_W term is implicit: it only decides whether to subtract.
  always_comb begin
    rem_next = {rem[CRC_W-2:0], bit_in} ^ (rem[CRC_W-1] ? POLY[CRC_W-1:0] : '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem <= '0;
    end else if (clr) begin
      rem <= '0;
    end else if (en) begin
      rem <= rem_next;
    end
  end

endmodule

// File: rtl/crc_checker.sv
// Receiver-side CRC-4 checker: accepts a {data, crc} codeword, divides it bit-serially,
// then presents payload, syndrome and error flag until the downstream accepts them.
module crc_checker #(
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       CRC_W  = 4,
  parameter logic [CRC_W:0]    POLY   = 5'b10011,
  parameter int unsigned       CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  crc_checker_if.slave      bus,
  output logic [CNT_W-1:0]  err_count,
  output logic              overrun
);

  import crc_pkg::*;

  localparam int unsigned CodeW = DATA_W + CRC_W;
  localparam int unsigned BitCntW = $clog2(CodeW);

  state_t               state_q, state_d;
  logic [CodeW-1:0]     shift_q;
  logic [DATA_W-1:0]    data_q;
  logic [BitCntW-1:0]   cnt_q;
  logic [DATA_W-1:0]    out_data_q;
  logic [CRC_W-1:0]     out_syndrome_q;
  logic                 out_crc_err_q;
  logic [CNT_W-1:0]     err_count_q;
  logic                 overrun_q;

  logic                 accept;
  logic                 last_bit;
  logic [CRC_W-1:0]     rem;
  logic [CRC_W-1:0]     rem_next;

  assign accept   = (state_q == StIdle) && bus.in_valid;
  assign last_bit = (state_q == StDivide) && (cnt_q == '0);

  crc_serial_div #(
    .CRC_W (CRC_W),
    .POLY  (POLY)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .en       (state_q == StDivide),
    .clr      (accept),
    .bit_in   (shift_q[CodeW-1]),
    .rem      (rem),
    .rem_next (rem_next)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.in_valid) state_d = StDivide;
      StDivide: if (cnt_q == '0) state_d = StDone;
      StDone:   if (bus.out_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      shift_q        <= '0;
      data_q         <= '0;
      cnt_q          <= '0;
      out_data_q     <= '0;
      out_syndrome_q <= '0;
      out_crc_err_q  <= 1'b0;
      err_count_q    <= '0;
      overrun_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      // The generator's done pulse cannot be stalled, so a busy checker drops it.
      if (bus.in_valid && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end
      if (accept) begin
        shift_q <= bus.in_codeword;
        data_q  <= bus.in_codeword[CodeW-1:CRC_W];
        cnt_q   <= BitCntW'(CodeW - 1);
      end else if (state_q == StDivide) begin
        shift_q <= shift_q << 1;
        cnt_q   <= cnt_q - BitCntW'(1);
      end
      if (last_bit) begin
        out_data_q     <= data_q;
        out_syndrome_q <= rem_next;
        out_crc_err_q  <= |rem_next;
        if ((|rem_next) && (err_count_q != '1)) begin
          err_count_q <= err_count_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.in_ready     = (state_q == StIdle);
  assign bus.out_valid    = (state_q == StDone);
  assign bus.out_data     = out_data_q;
  assign bus.out_syndrome = out_syndrome_q;
  assign bus.out_crc_err  = out_crc_err_q;
  assign err_count        = err_count_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_crc_checker.sv
// Directed bench for crc_checker: hand-computed CRC-4 syndromes, backpressure,
// overrun, counter saturation and asynchronous reset mid-division.
module tb_crc_checker;

  logic       clk;
  logic       rst;
  logic [7:0] err_count;
  logic       overrun;

  int checks;
  int failures;

  crc_checker_if bus ();

  crc_checker dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err_count (err_count),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] cw);
    bus.in_valid    = 1'b1;
    bus.in_codeword = cw;
    step();
    bus.in_valid    = 1'b0;
  endtask

  // Counts edges after the accepting edge until out_valid is seen, bounded.
  task automatic wait_valid(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  int  lat;
  int  stable;
  logic [7:0] held_data;
  logic [3:0] held_syn;
  logic       held_err;

  initial begin
    checks          = 0;
    failures        = 0;
    rst             = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_codeword = '0;
    bus.out_ready   = 1'b0;
    step();
    step();

    // Reset state
    check("rst_in_ready",  32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data), 32'd0);
    check("rst_syndrome",  32'(bus.out_syndrome), 32'd0);
    check("rst_crc_err",   32'(bus.out_crc_err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_overrun",   32'(overrun), 32'd0);
    rst = 1'b1;
    step();

    // Valid codeword A5B, 12-cycle latency
    bus.out_ready = 1'b1;
    send(12'hA5B);
    check("valid_in_ready_busy", 32'(bus.in_ready), 32'd0);
    wait_valid(lat);
    check("valid_latency",   32'(lat), 32'd12);
    check("valid_out_data",  32'(bus.out_data), 32'hA5);
    check("valid_syndrome",  32'(bus.out_syndrome), 32'h0);
    check("valid_crc_err",   32'(bus.out_crc_err), 32'd0);
    check("valid_err_count", 32'(err_count), 32'd0);
    step();
    check("valid_drop_valid", 32'(bus.out_valid), 32'd0);
    check("valid_in_ready",   32'(bus.in_ready), 32'd1);

    // Single-bit error at bit 8: syndrome = x^8 mod poly = x^2+1
    send(12'hB5B);
    wait_valid(lat);
    check("err_latency",   32'(lat), 32'd12);
    check("err_out_data",  32'(bus.out_data), 32'hB5);
    check("err_syndrome",  32'(bus.out_syndrome), 32'h5);
    check("err_crc_err",   32'(bus.out_crc_err), 32'd1);
    check("err_err_count", 32'(err_count), 32'd1);
    step();

    // Backpressure: result must hold while out_ready is low
    bus.out_ready = 1'b0;
    send(12'hA5B);
    wait_valid(lat);
    check("bp_latency", 32'(lat), 32'd12);
    held_data = bus.out_data;
    held_syn  = bus.out_syndrome;
    held_err  = bus.out_crc_err;
    stable    = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_data !== held_data ||
          bus.out_syndrome !== held_syn || bus.out_crc_err !== held_err) begin
        stable = 0;
      end
    end
    check("bp_stable",   32'(stable), 32'd1);
    check("bp_out_data", 32'(bus.out_data), 32'hA5);
    check("bp_syndrome", 32'(bus.out_syndrome), 32'h0);
    bus.out_ready = 1'b1;
    step();
    check("bp_release_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    check("bp_err_count",     32'(err_count), 32'd1);

    // Overrun: second word arrives while dividing and is dropped
    send(12'h000);
    step();
    step();
    check("ovr_before", 32'(overrun), 32'd0);
    send(12'hFFF);
    check("ovr_set", 32'(overrun), 32'd1);
    wait_valid(lat);
    check("ovr_valid",     32'(bus.out_valid), 32'd1);
    check("ovr_out_data",  32'(bus.out_data), 32'h00);
    check("ovr_syndrome",  32'(bus.out_syndrome), 32'h0);
    check("ovr_crc_err",   32'(bus.out_crc_err), 32'd0);
    step();
    for (int i = 0; i < 14; i++) step();
    check("ovr_no_second", 32'(bus.out_valid), 32'd0);
    check("ovr_sticky",    32'(overrun), 32'd1);

    // Saturation: 260 words with a bit-4 error (syndrome x+1)
    for (int i = 0; i < 260; i++) begin
      send(12'hA4B);
      wait_valid(lat);
      if (i == 0) begin
        check("sat_syndrome", 32'(bus.out_syndrome), 32'h3);
        check("sat_out_data", 32'(bus.out_data), 32'hA4);
      end
      if (i == 252) check("sat_count_254", 32'(err_count), 32'hFE);
      if (i == 253) check("sat_count_255", 32'(err_count), 32'hFF);
      step();
    end
    check("sat_final",      32'(err_count), 32'hFF);
    check("sat_overrun",    32'(overrun), 32'd1);

    // Asynchronous reset during DIVIDE aborts the word
    send(12'hB5B);
    for (int i = 0; i < 4; i++) step();
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready",  32'(bus.in_ready), 32'd1);
    check("mid_rst_err_count", 32'(err_count), 32'd0);
    check("mid_rst_overrun",   32'(overrun), 32'd0);
    check("mid_rst_syndrome",  32'(bus.out_syndrome), 32'd0);
    step();
    rst = 1'b1;
    stable = 1;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.out_valid !== 1'b0) stable = 0;
    end
    check("mid_rst_no_valid", 32'(stable), 32'd1);
    send(12'hA5B);
    wait_valid(lat);
    check("post_rst_latency",  32'(lat), 32'd12);
    check("post_rst_out_data", 32'(bus.out_data), 32'hA5);
    check("post_rst_syndrome", 32'(bus.out_syndrome), 32'h0);
    check("post_rst_crc_err",  32'(bus.out_crc_err), 32'd0);
    step();
    check("post_rst_idle", 32'(bus.in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
